// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank: channel modes and per-channel step.
package counter_bank_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      UP     = 2'd1,
      DOWN   = 2'd2,
      BOUNCE = 2'd3
   } mode_e;

   // Untruncated step of channel i; callers narrow it to the counter width.
   function automatic int unsigned chan_step(input int unsigned base,
                                             input int unsigned incr,
                                             input int unsigned i);
      return base + i * incr;
   endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Control/status bundle between the display host and the counter bank.
interface counter_bank_if
   import counter_bank_pkg::*;
#(
   parameter int unsigned NBITS = 8,
   parameter int unsigned NCHAN = 4,
   parameter int unsigned SELW  = 3
);
   logic             en;
   logic             sat;
   logic             wr;
   logic [SELW-1:0]  chan_sel;
   logic [NBITS-1:0] load_val;
   mode_e            mode;
   logic [NBITS-1:0] count_sel;
   logic [NCHAN-1:0] ovf;
   logic             any_ovf;

   modport master (
      output en, sat, wr, chan_sel, load_val, mode,
      input  count_sel, ovf, any_ovf
   );

   modport slave (
      input  en, sat, wr, chan_sel, load_val, mode,
      output count_sel, ovf, any_ovf
   );
endinterface

// File: rtl/counter_bank_chan.sv
// One loadable step counter with up/down/bounce modes, wrap or saturate, sticky overflow.
module counter_chan
   import counter_bank_pkg::*;
#(
   parameter int unsigned      NBITS = 8,
   parameter logic [NBITS-1:0] STEP  = '0
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic             en,
   input  logic             sat,
   input  logic             wr_hit,
   input  logic [NBITS-1:0] load_val,
   input  mode_e            mode,
   output logic [NBITS-1:0] cnt,
   output logic             ovf
);
   localparam logic [NBITS-1:0] MAX = '1;

   mode_e            mode_q;
   logic             dir;
   logic [NBITS:0]   sum;
   logic [NBITS-1:0] diff;
   logic             over;
   logic             under;

   // One-bit-wider sum exposes the carry; underflow is a plain compare.
   always_comb begin
      sum   = {1'b0, cnt} + {1'b0, STEP};
      diff  = cnt - STEP;
      over  = sum[NBITS];
      under = (STEP > cnt);
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         cnt    <= '0;
         mode_q <= HOLD;
         dir    <= 1'b0;
         ovf    <= 1'b0;
      end else if (wr_hit) begin
         cnt    <= load_val;
         mode_q <= mode;
         dir    <= (mode == DOWN);
         ovf    <= 1'b0;
      end else if (en) begin
         case (mode_q)
            UP: begin
               cnt <= (over && sat) ? MAX : sum[NBITS-1:0];
               if (over) ovf <= 1'b1;
            end
            DOWN: begin
               cnt <= (under && sat) ? '0 : diff;
               if (under) ovf <= 1'b1;
            end
            BOUNCE: begin
               if (!dir) begin
                  if (over) begin
                     cnt <= MAX;
                     dir <= 1'b1;
                     ovf <= 1'b1;
                  end else begin
                     cnt <= sum[NBITS-1:0];
                  end
               end else begin
                  if (under) begin
                     cnt <= '0;
                     dir <= 1'b0;
                     ovf <= 1'b1;
                  end else begin
                     cnt <= diff;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent step counters with write decode, display mux and overflow summary.
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter int unsigned NBITS     = 8,
   parameter int unsigned NCHAN     = 4,
   parameter int unsigned SELW      = 3,
   parameter int unsigned STEP_BASE = 3,
   parameter int unsigned STEP_INCR = 3
) (
   input logic            clk_2,
   input logic            reset,
   counter_bank_if.slave  bus
);
   logic [NBITS-1:0] cnts [NCHAN];
   logic [NCHAN-1:0] ovf_v;
   logic [NBITS-1:0] sel_cnt;

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      localparam logic [NBITS-1:0] STEP = NBITS'(chan_step(STEP_BASE, STEP_INCR, i));

      // Out-of-range selects never match any channel, so such writes are dropped.
      logic wr_hit;
      assign wr_hit = bus.wr && (bus.chan_sel == SELW'(i));

      counter_chan #(
         .NBITS (NBITS),
         .STEP  (STEP)
      ) u_chan (
         .clk_2    (clk_2),
         .reset    (reset),
         .en       (bus.en),
         .sat      (bus.sat),
         .wr_hit   (wr_hit),
         .load_val (bus.load_val),
         .mode     (bus.mode),
         .cnt      (cnts[i]),
         .ovf      (ovf_v[i])
      );
   end

   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (bus.chan_sel == SELW'(i)) sel_cnt = cnts[i];
      end
   end

   assign bus.count_sel = sel_cnt;
   assign bus.ovf       = ovf_v;
   assign bus.any_ovf   = |ovf_v;

endmodule
